// File: rtl/input_sram_loader.sv
// Packs a binary pixel stream into input-SRAM matrix images: row count, column count, then one word per row.
// Latency: header words 1 and 2 cycles after start; row word 1 cycle after its last pixel; ncols+1 cycles per row.
// Backpressure: pix_ready only in FILL, stalls indefinitely on pix_valid gaps. LOADER_DIM_CHECK_EN enables the dimension check.
module input_sram_loader #(
    parameter logic [11:0] BASE_ADDR  = 12'h000,
    parameter logic [15:0] TERMINATOR = 16'h00FF
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        start,
    input  logic [4:0]  cfg_nrows,
    input  logic [4:0]  cfg_ncols,
    input  logic        finish,
    input  logic        pix_valid,
    input  logic        pix_data,
    output logic        pix_ready,
    output logic        loader_busy,
    output logic        done,
    output logic        err,
    output logic [11:0] loader_sram_write_address,
    output logic [15:0] loader_sram_write_data,
    output logic        loader_sram_write_enable
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HDR_R = 3'd1;
    localparam logic [2:0] HDR_C = 3'd2;
    localparam logic [2:0] FILL  = 3'd3;
    localparam logic [2:0] WROW  = 3'd4;
    localparam logic [2:0] TERM  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [4:0]  nrows_q, nrows_d;
    logic [4:0]  ncols_q, ncols_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  col_q, col_d;
    logic [15:0] rowbuf_q, rowbuf_d;
    logic [11:0] ptr_q, ptr_d;
    logic [11:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic        dims_ok;
    logic        dims_bad;

`ifdef LOADER_DIM_CHECK_EN
    logic        err_q;

    assign dims_ok  = (cfg_nrows >= 5'd3) && (cfg_nrows <= 5'd16) &&
                      (cfg_ncols >= 5'd3) && (cfg_ncols <= 5'd16);
    assign dims_bad = (state_q == IDLE) && start && !dims_ok;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            err_q <= 1'b0;
        end else if (dims_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign dims_ok  = 1'b1;
    assign dims_bad = 1'b0;
    assign err      = 1'b0;
`endif

    // The write a state performs is registered on the transition into it,
    // so the strobe is visible in the same cycle the FSM sits in that state.
    always_comb begin
        state_d  = state_q;
        nrows_d  = nrows_q;
        ncols_d  = ncols_q;
        row_d    = row_q;
        col_d    = col_q;
        rowbuf_d = rowbuf_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (dims_ok && !dims_bad) begin
                        nrows_d  = cfg_nrows;
                        ncols_d  = cfg_ncols;
                        row_d    = 5'd0;
                        col_d    = 5'd0;
                        rowbuf_d = 16'h0000;
                        state_d  = HDR_R;
                        we_d     = 1'b1;
                        data_d   = {11'b0, cfg_nrows};
                    end
                end else if (finish) begin
                    state_d = TERM;
                    we_d    = 1'b1;
                    data_d  = TERMINATOR;
                end
            end
            HDR_R: begin
                state_d = HDR_C;
                we_d    = 1'b1;
                data_d  = {11'b0, ncols_q};
            end
            HDR_C: begin
                state_d = FILL;
            end
            FILL: begin
                if (pix_valid) begin
                    if (!col_q[4]) begin
                        rowbuf_d[col_q[3:0]] = pix_data;
                    end
                    col_d = col_q + 5'd1;
                    if (col_q == (ncols_q - 5'd1)) begin
                        state_d = WROW;
                        we_d    = 1'b1;
                        data_d  = rowbuf_d;
                    end
                end
            end
            WROW: begin
                rowbuf_d = 16'h0000;
                col_d    = 5'd0;
                row_d    = row_q + 5'd1;
                if (row_q == (nrows_q - 5'd1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = FILL;
                end
            end
            TERM: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (we_d) begin
            addr_d = ptr_q;
            ptr_d  = ptr_q + 12'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= IDLE;
            nrows_q  <= 5'd0;
            ncols_q  <= 5'd0;
            row_q    <= 5'd0;
            col_q    <= 5'd0;
            rowbuf_q <= 16'h0000;
            ptr_q    <= BASE_ADDR;
            addr_q   <= BASE_ADDR;
            data_q   <= 16'h0000;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            nrows_q  <= nrows_d;
            ncols_q  <= ncols_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rowbuf_q <= rowbuf_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            done_q   <= done_d;
        end
    end

    assign pix_ready                 = (state_q == FILL);
    assign loader_busy               = (state_q != IDLE);
    assign done                      = done_q;
    assign loader_sram_write_address = addr_q;
    assign loader_sram_write_data    = data_q;
    assign loader_sram_write_enable  = we_q;

endmodule

// File: tb/tb_input_sram_loader.sv
// Directed bench for input_sram_loader: header/row/terminator writes, timing, pointer wrap and mid-row reset.
module tb_input_sram_loader;

    typedef logic [15:0] rows_t [16];

    logic        clk = 1'b0;
    logic        reset_b;
    logic        start;
    logic [4:0]  cfg_nrows;
    logic [4:0]  cfg_ncols;
    logic        finish;
    logic        pix_valid;
    logic        pix_data;
    logic        pix_ready;
    logic        loader_busy;
    logic        done;
    logic        err;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;

    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    logic [11:0] log_addr [$];
    logic [15:0] log_data [$];
    rows_t       img;

    always #5 clk = ~clk;

    input_sram_loader #(
        .BASE_ADDR  (12'h000),
        .TERMINATOR (16'h00FF)
    ) dut (
        .clk                       (clk),
        .reset_b                   (reset_b),
        .start                     (start),
        .cfg_nrows                 (cfg_nrows),
        .cfg_ncols                 (cfg_ncols),
        .finish                    (finish),
        .pix_valid                 (pix_valid),
        .pix_data                  (pix_data),
        .pix_ready                 (pix_ready),
        .loader_busy               (loader_busy),
        .done                      (done),
        .err                       (err),
        .loader_sram_write_address (wr_addr),
        .loader_sram_write_data    (wr_data),
        .loader_sram_write_enable  (wr_en)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_b === 1'b1) begin
            if (wr_en === 1'b1) begin
                log_addr.push_back(wr_addr);
                log_data.push_back(wr_data);
                chk("ready_low_on_write", {31'b0, pix_ready}, 32'd0);
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        reset_b = 1'b0;
        tick();
        reset_b = 1'b1;
        tick();
    endtask

    task automatic check_write(input int idx, input logic [11:0] a, input logic [15:0] d);
        if (idx < log_addr.size()) begin
            chk($sformatf("wr%0d_addr", idx), {20'b0, log_addr[idx]}, {20'b0, a});
            chk($sformatf("wr%0d_data", idx), {16'b0, log_data[idx]}, {16'b0, d});
        end else begin
            chk($sformatf("wr%0d_missing", idx), log_addr.size(), idx + 1);
        end
    endtask

    task automatic start_mat(input logic [4:0] nr, input logic [4:0] nc);
        start     = 1'b1;
        cfg_nrows = nr;
        cfg_ncols = nc;
        tick();
        start  = 1'b0;
        finish = 1'b0;
    endtask

    task automatic send_pix(input logic b, input int max_gap);
        int budget;
        if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) tick();
        pix_valid = 1'b1;
        pix_data  = b;
        budget    = 0;
        while (pix_ready !== 1'b1 && budget < 50) begin
            tick();
            budget++;
        end
        if (budget >= 50) chk("pix_ready_timeout", {31'b0, pix_ready}, 32'd1);
        tick();
        pix_valid = 1'b0;
        pix_data  = 1'b0;
    endtask

    task automatic load(input int nr, input int nc, input int max_gap);
        start_mat(nr[4:0], nc[4:0]);
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++)
                send_pix(img[r][c], max_gap);
        tick();
        tick();
    endtask

    task automatic set3x3();
        for (int i = 0; i < 16; i++) img[i] = 16'h0000;
        img[0] = 16'h0005;
        img[1] = 16'h0002;
        img[2] = 16'h0007;
    endtask

    initial begin
        reset_b   = 1'b0;
        start     = 1'b0;
        finish    = 1'b0;
        cfg_nrows = 5'd0;
        cfg_ncols = 5'd0;
        pix_valid = 1'b0;
        pix_data  = 1'b0;
        tick();
        tick();
        chk("rst_ready", {31'b0, pix_ready}, 32'd0);
        chk("rst_busy",  {31'b0, loader_busy}, 32'd0);
        chk("rst_done",  {31'b0, done}, 32'd0);
        chk("rst_err",   {31'b0, err}, 32'd0);
        chk("rst_addr",  {20'b0, wr_addr}, 32'h000);
        chk("rst_data",  {16'b0, wr_data}, 32'h0000);
        chk("rst_we",    {31'b0, wr_en}, 32'd0);
        reset_b = 1'b1;
        tick();

        // 3x3 back-to-back with cycle-exact timing
        clear_log();
        set3x3();
        start_mat(5'd3, 5'd3);
        chk("t1_we",    {31'b0, wr_en}, 32'd1);
        chk("t1_addr",  {20'b0, wr_addr}, 32'h000);
        chk("t1_data",  {16'b0, wr_data}, 32'h0003);
        chk("t1_busy",  {31'b0, loader_busy}, 32'd1);
        chk("t1_ready", {31'b0, pix_ready}, 32'd0);
        tick();
        chk("t2_we",    {31'b0, wr_en}, 32'd1);
        chk("t2_addr",  {20'b0, wr_addr}, 32'h001);
        chk("t2_data",  {16'b0, wr_data}, 32'h0003);
        tick();
        chk("t3_ready", {31'b0, pix_ready}, 32'd1);
        chk("t3_we",    {31'b0, wr_en}, 32'd0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                send_pix(img[r][c], 0);
        chk("wrow_we",    {31'b0, wr_en}, 32'd1);
        chk("wrow_addr",  {20'b0, wr_addr}, 32'h004);
        chk("wrow_data",  {16'b0, wr_data}, 32'h0007);
        chk("wrow_ready", {31'b0, pix_ready}, 32'd0);
        chk("wrow_done",  {31'b0, done}, 32'd0);
        tick();
        chk("done_hi",   {31'b0, done}, 32'd1);
        chk("done_busy", {31'b0, loader_busy}, 32'd0);
        tick();
        chk("done_lo", {31'b0, done}, 32'd0);
        chk("m3_count", log_addr.size(), 5);
        check_write(0, 12'h000, 16'h0003);
        check_write(1, 12'h001, 16'h0003);
        check_write(2, 12'h002, 16'h0005);
        check_write(3, 12'h003, 16'h0002);
        check_write(4, 12'h004, 16'h0007);
        chk("m3_dones", done_cnt, 1);

        // 16x16 all ones with random valid gaps
        do_reset();
        clear_log();
        for (int i = 0; i < 16; i++) img[i] = 16'hFFFF;
        load(16, 16, 3);
        chk("m16_count", log_addr.size(), 18);
        check_write(0, 12'h000, 16'h0010);
        check_write(1, 12'h001, 16'h0010);
        for (int i = 0; i < 16; i++) check_write(2 + i, 12'(2 + i), 16'hFFFF);
        chk("m16_dones", done_cnt, 1);

        // two 4x5 matrices (second start collides with finish) then a terminator
        do_reset();
        clear_log();
        for (int i = 0; i < 16; i++) img[i] = 16'h0000;
        img[0] = 16'h0015;
        img[1] = 16'h000A;
        img[2] = 16'h001F;
        img[3] = 16'h0001;
        load(4, 5, 0);
        finish = 1'b1;
        load(4, 5, 1);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        chk("term_we",   {31'b0, wr_en}, 32'd1);
        chk("term_addr", {20'b0, wr_addr}, 32'h00C);
        chk("term_data", {16'b0, wr_data}, 32'h00FF);
        tick();
        chk("term_done", {31'b0, done}, 32'd1);
        tick();
        chk("m45_count", log_addr.size(), 13);
        for (int m = 0; m < 2; m++) begin
            check_write(6 * m,     12'(6 * m),     16'h0004);
            check_write(6 * m + 1, 12'(6 * m + 1), 16'h0005);
            for (int r = 0; r < 4; r++) check_write(6 * m + 2 + r, 12'(6 * m + 2 + r), img[r]);
        end
        check_write(12, 12'h00C, 16'h00FF);
        chk("m45_dones", done_cnt, 3);

`ifdef LOADER_DIM_CHECK_EN
        do_reset();
        clear_log();
        start_mat(5'd2, 5'd4);
        chk("bad_err",  {31'b0, err}, 32'd1);
        chk("bad_we",   {31'b0, wr_en}, 32'd0);
        chk("bad_busy", {31'b0, loader_busy}, 32'd0);
        tick();
        set3x3();
        load(3, 3, 0);
        chk("bad_then_count", log_addr.size(), 5);
        check_write(0, 12'h000, 16'h0003);
        check_write(2, 12'h002, 16'h0005);
        chk("bad_err_sticky", {31'b0, err}, 32'd1);
`else
        chk("err_const", {31'b0, err}, 32'd0);
`endif

        // 4095 terminators leave the pointer at FFF, then a matrix wraps
        do_reset();
        clear_log();
        finish = 1'b1;
        repeat (8190) tick();
        finish = 1'b0;
        chk("pre_wrap_count", log_addr.size(), 4095);
        check_write(4094, 12'hFFE, 16'h00FF);
        tick();
        clear_log();
        set3x3();
        load(3, 3, 0);
        chk("wrap_count", log_addr.size(), 5);
        check_write(0, 12'hFFF, 16'h0003);
        check_write(1, 12'h000, 16'h0003);
        check_write(2, 12'h001, 16'h0005);
        check_write(4, 12'h003, 16'h0007);

        // reset mid-row at col 7
        do_reset();
        clear_log();
        start_mat(5'd3, 5'd10);
        for (int c = 0; c < 7; c++) send_pix(1'b1, 0);
        clear_log();
        reset_b = 1'b0;
        #1;
        chk("mid_ready", {31'b0, pix_ready}, 32'd0);
        chk("mid_busy",  {31'b0, loader_busy}, 32'd0);
        chk("mid_we",    {31'b0, wr_en}, 32'd0);
        chk("mid_addr",  {20'b0, wr_addr}, 32'h000);
        chk("mid_data",  {16'b0, wr_data}, 32'h0000);
        chk("mid_done",  {31'b0, done}, 32'd0);
        tick();
        reset_b = 1'b1;
        tick();
        tick();
        chk("mid_no_write", log_addr.size(), 0);
        set3x3();
        load(3, 3, 0);
        chk("post_mid_count", log_addr.size(), 5);
        check_write(0, 12'h000, 16'h0003);
        check_write(3, 12'h003, 16'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
